// File: rtl/ppi_mode1_handshake_if.sv
// Bundles the CPU-side and peripheral-side signals of one Mode 1 strobed port.
interface ppi_mode1_handshake_if;
   localparam int unsigned DATA_W = 8;

   logic              dir;
   logic              inte_set;
   logic              inte_clr;
   logic              cpu_rd_n;
   logic              cpu_wr_n;
   logic [DATA_W-1:0] cpu_din;
   logic [DATA_W-1:0] cpu_dout;
   logic [DATA_W-1:0] port_in;
   logic [DATA_W-1:0] port_out;
   logic              port_oe;
   logic              stb_n;
   logic              ibf;
   logic              ack_n;
   logic              obf_n;
   logic              intr;
   logic              inte;
   logic              err_ovr;

   // Port block side
   modport slave (
      input  dir, inte_set, inte_clr, cpu_rd_n, cpu_wr_n, cpu_din, port_in, stb_n, ack_n,
      output cpu_dout, port_out, port_oe, ibf, obf_n, intr, inte, err_ovr
   );

   // CPU / peripheral driver side
   modport master (
      output dir, inte_set, inte_clr, cpu_rd_n, cpu_wr_n, cpu_din, port_in, stb_n, ack_n,
      input  cpu_dout, port_out, port_oe, ibf, obf_n, intr, inte, err_ovr
   );
endinterface

// File: rtl/ppi_mode1_handshake.sv
// Mode 1 strobed I/O handshake for one PPI port: input (STB/IBF) and output (ACK/OBF) paths.
// SYNC_STAGES must lie in 2..4.
module ppi_mode1_handshake #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic                   clk,
   input logic                   reset_n,
   ppi_mode1_handshake_if.slave  bus
);

   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      IN_IDLE  = 2'd0,
      IN_LATCH = 2'd1,
      IN_FULL  = 2'd2,
      IN_READ  = 2'd3
   } in_state_t;

   typedef enum logic [1:0] {
      OUT_EMPTY = 2'd0,
      OUT_FULL  = 2'd1,
      OUT_ACK   = 2'd2
   } out_state_t;

   // Synchronizers and edge-detect copies
   logic [SYNC_STAGES-1:0] stb_sync;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   stb_dly;
   logic                   ack_dly;
   logic                   stb_armed;
   logic                   ack_armed;
   logic                   run;
   logic                   rd_q;
   logic                   wr_q;

   // Control state and registered outputs
   in_state_t              in_state,  in_nxt;
   out_state_t             out_state, out_nxt;
   logic                   dir_q;
   logic                   ibf,      ibf_nxt;
   logic                   obf_n,    obf_n_nxt;
   logic                   intr,     intr_nxt;
   logic                   inte,     inte_nxt;
   logic                   err_ovr,  err_nxt;
   logic [DATA_W-1:0]      cpu_dout, dout_nxt;
   logic [DATA_W-1:0]      port_out, pout_nxt;
   logic                   port_oe;
   logic                   ovr_c;

   logic stb_fall_c, stb_rise_c, ack_fall_c, ack_rise_c;
   logic rd_fall_c,  rd_rise_c,  wr_fall_c,  wr_rise_c;
   logic dir_chg_c;

   // A falling edge counts only once the line has been seen high since reset,
   // so a strobe/acknowledge held low across reset release is not taken as an edge.
   assign stb_fall_c = stb_dly & ~stb_sync[SYNC_STAGES-1] & stb_armed;
   assign stb_rise_c = ~stb_dly & stb_sync[SYNC_STAGES-1];
   assign ack_fall_c = ack_dly & ~ack_sync[SYNC_STAGES-1] & ack_armed;
   assign ack_rise_c = ~ack_dly & ack_sync[SYNC_STAGES-1];
   assign rd_fall_c  = rd_q & ~bus.cpu_rd_n;
   assign rd_rise_c  = ~rd_q & bus.cpu_rd_n;
   assign wr_fall_c  = wr_q & ~bus.cpu_wr_n;
   assign wr_rise_c  = ~wr_q & bus.cpu_wr_n;
   assign dir_chg_c  = bus.dir != dir_q;

   // Synchronize STB_N/ACK_N and keep one-cycle copies of all edge-detected lines
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stb_sync  <= '1;
         ack_sync  <= '1;
         stb_dly   <= 1'b1;
         ack_dly   <= 1'b1;
         stb_armed <= 1'b0;
         ack_armed <= 1'b0;
         run       <= 1'b0;
         rd_q      <= 1'b1;
         wr_q      <= 1'b1;
      end else begin
         stb_sync  <= {stb_sync[SYNC_STAGES-2:0], bus.stb_n};
         ack_sync  <= {ack_sync[SYNC_STAGES-2:0], bus.ack_n};
         stb_dly   <= stb_sync[SYNC_STAGES-1];
         ack_dly   <= ack_sync[SYNC_STAGES-1];
         stb_armed <= stb_armed | (run & stb_sync[0]);
         ack_armed <= ack_armed | (run & ack_sync[0]);
         run       <= 1'b1;
         rd_q      <= bus.cpu_rd_n;
         wr_q      <= bus.cpu_wr_n;
      end
   end

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         in_state  <= IN_IDLE;
         out_state <= OUT_EMPTY;
         dir_q     <= bus.dir;
         ibf       <= 1'b0;
         obf_n     <= 1'b1;
         intr      <= 1'b0;
         inte      <= 1'b0;
         err_ovr   <= 1'b0;
         cpu_dout  <= '0;
         port_out  <= '0;
         port_oe   <= ~bus.dir;
      end else begin
         in_state  <= in_nxt;
         out_state <= out_nxt;
         dir_q     <= bus.dir;
         ibf       <= ibf_nxt;
         obf_n     <= obf_n_nxt;
         intr      <= intr_nxt;
         inte      <= inte_nxt;
         err_ovr   <= err_nxt;
         cpu_dout  <= dout_nxt;
         port_out  <= pout_nxt;
         port_oe   <= ~bus.dir;
      end
   end

   // Next-state and next-output logic for both handshake directions
   always_comb begin
      in_nxt    = in_state;
      out_nxt   = out_state;
      ibf_nxt   = ibf;
      obf_n_nxt = obf_n;
      intr_nxt  = intr;
      inte_nxt  = inte;
      err_nxt   = err_ovr;
      dout_nxt  = cpu_dout;
      pout_nxt  = port_out;
      ovr_c     = 1'b0;

      if (bus.inte_clr) begin
         inte_nxt = 1'b0;
      end else if (bus.inte_set) begin
         inte_nxt = 1'b1;
      end

      if (dir_chg_c) begin
         // Direction switch abandons any handshake; data registers keep their values.
         in_nxt    = IN_IDLE;
         out_nxt   = OUT_EMPTY;
         ibf_nxt   = 1'b0;
         intr_nxt  = 1'b0;
         obf_n_nxt = 1'b1;
      end else if (dir_q) begin
         case (in_state)
            IN_IDLE: begin
               if (stb_fall_c) begin
                  dout_nxt = bus.port_in;
                  ibf_nxt  = 1'b1;
                  in_nxt   = IN_LATCH;
               end
            end
            IN_LATCH: begin
               if (stb_fall_c) begin
                  ovr_c = 1'b1;
               end else if (stb_rise_c) begin
                  in_nxt = IN_FULL;
                  if (inte) begin
                     intr_nxt = 1'b1;
                  end
               end
            end
            IN_FULL: begin
               if (stb_fall_c) begin
                  ovr_c = 1'b1;
               end
               if (rd_fall_c) begin
                  in_nxt   = IN_READ;
                  intr_nxt = 1'b0;
               end
            end
            IN_READ: begin
               if (rd_rise_c && stb_fall_c) begin
                  // Read completes on the same edge a new byte arrives: take it, no overrun.
                  dout_nxt = bus.port_in;
                  in_nxt   = IN_LATCH;
               end else if (rd_rise_c) begin
                  ibf_nxt = 1'b0;
                  in_nxt  = IN_IDLE;
               end else if (stb_fall_c) begin
                  ovr_c = 1'b1;
               end
            end
            default: in_nxt = IN_IDLE;
         endcase

         if (ovr_c) begin
            err_nxt = 1'b1;
         end else if (rd_fall_c) begin
            err_nxt = 1'b0;
         end
      end else begin
         if (wr_rise_c) begin
            // A CPU write always wins over an acknowledge completing the same cycle.
            pout_nxt  = bus.cpu_din;
            intr_nxt  = 1'b0;
            obf_n_nxt = 1'b0;
            out_nxt   = OUT_FULL;
            if (out_state == OUT_FULL) begin
               ovr_c = 1'b1;
            end
         end else begin
            case (out_state)
               OUT_EMPTY: out_nxt = OUT_EMPTY;
               OUT_FULL: begin
                  if (ack_fall_c) begin
                     out_nxt   = OUT_ACK;
                     obf_n_nxt = 1'b1;
                  end
               end
               OUT_ACK: begin
                  if (ack_rise_c) begin
                     out_nxt = OUT_EMPTY;
                     if (inte) begin
                        intr_nxt = 1'b1;
                     end
                  end
               end
               default: out_nxt = OUT_EMPTY;
            endcase
         end

         if (ovr_c) begin
            err_nxt = 1'b1;
         end else if (wr_fall_c) begin
            err_nxt = 1'b0;
         end
      end

      if (bus.inte_clr) begin
         intr_nxt = 1'b0;
      end
   end

   assign bus.ibf      = ibf;
   assign bus.obf_n    = obf_n;
   assign bus.intr     = intr;
   assign bus.inte     = inte;
   assign bus.err_ovr  = err_ovr;
   assign bus.cpu_dout = cpu_dout;
   assign bus.port_out = port_out;
   assign bus.port_oe  = port_oe;

endmodule
